// File: rtl/dm_responder.sv
// Data-memory responder: serves one CPU load/store at a time after LATENCY wait cycles.
// Stores honour sw/sh/sb strobes (sw > sh > sb). Loads use the DMEXTOp-style extension code.
// The response is held until the consumer accepts it. The whole store is cleared on reset.
// Optional: define DM_WRITE_LOG_EN to print one line per committed store.
module dm_responder #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        sw,
    input  logic        sh,
    input  logic        sb,
    input  logic [2:0]  dmext_op,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam logic [3:0] CntInit = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        sw_q, sh_q, sb_q;
    logic [2:0]  op_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    logic [31:0] mem_q [Depth];

    logic              accept;
    logic              access_fire;
    logic              acc_we;
    logic [31:0]       acc_addr;
    logic [31:0]       acc_wdata;
    logic              acc_sw, acc_sh, acc_sb;
    logic [2:0]        acc_op;
    logic [ADDR_W-1:0] acc_idx;
    logic [31:0]       cur_word;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic              acc_err;
    logic [31:0]       acc_rdata;
    logic              wr_en;
    logic [31:0]       wr_word;
    logic              unused_addr;

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    assign accept = (state_q == StIdle) && req_valid;
    // With zero latency the access happens on the accepting edge, using the live request.
    assign access_fire = (LATENCY == 0) ? accept : ((state_q == StWait) && (cnt_q == 4'd0));

    // Access operands: live inputs while idle, captured copies otherwise.
    always_comb begin
        if (state_q == StIdle) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_sw    = sw;
            acc_sh    = sh;
            acc_sb    = sb;
            acc_op    = dmext_op;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_sw    = sw_q;
            acc_sh    = sh_q;
            acc_sb    = sb_q;
            acc_op    = op_q;
        end
    end

    assign acc_idx     = acc_addr[ADDR_W+1:2];
    assign cur_word    = mem_q[acc_idx];
    assign unused_addr = ^acc_addr[31:ADDR_W+2];

    // Decode the access: lane selection, extension, alignment errors and the merged store word.
    always_comb begin
        acc_err   = 1'b0;
        acc_rdata = 32'h0;
        wr_en     = 1'b0;
        wr_word   = cur_word;
        lane_b    = cur_word[{acc_addr[1:0], 3'b000} +: 8];
        lane_h    = acc_addr[1] ? cur_word[31:16] : cur_word[15:0];
        if (acc_we) begin
            if (acc_sw) begin
                if (acc_addr[1:0] != 2'b00) begin
                    acc_err = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    wr_word = acc_wdata;
                end
            end else if (acc_sh) begin
                if (acc_addr[0]) begin
                    acc_err = 1'b1;
                end else begin
                    wr_en = 1'b1;
                    wr_word[{acc_addr[1], 4'b0000} +: 16] = acc_wdata[15:0];
                end
            end else if (acc_sb) begin
                wr_en = 1'b1;
                wr_word[{acc_addr[1:0], 3'b000} +: 8] = acc_wdata[7:0];
            end else begin
                acc_err = 1'b1;
            end
        end else begin
            case (acc_op)
                3'b001: acc_rdata = {24'h0, lane_b};
                3'b010: acc_rdata = {{24{lane_b[7]}}, lane_b};
                3'b011, 3'b100: begin
                    if (acc_addr[0]) begin
                        acc_err = 1'b1;
                    end else if (acc_op == 3'b100) begin
                        acc_rdata = {{16{lane_h[15]}}, lane_h};
                    end else begin
                        acc_rdata = {16'h0, lane_h};
                    end
                end
                default: begin
                    if (acc_addr[1:0] != 2'b00) begin
                        acc_err = 1'b1;
                    end else begin
                        acc_rdata = cur_word;
                    end
                end
            endcase
        end
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            sw_q         <= 1'b0;
            sh_q         <= 1'b0;
            sb_q         <= 1'b0;
            op_q         <= 3'b000;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        we_q        <= req_we;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        sw_q        <= sw;
                        sh_q        <= sh;
                        sb_q        <= sb;
                        op_q        <= dmext_op;
                        req_ready_q <= 1'b0;
                        if (access_fire) begin
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= acc_rdata;
                            resp_err_q   <= acc_err;
                            state_q      <= StResp;
                        end else begin
                            cnt_q   <= CntInit;
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (access_fire) begin
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= acc_rdata;
                        resp_err_q   <= acc_err;
                        state_q      <= StResp;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_rdata_q <= 32'h0;
                        resp_err_q   <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= StIdle;
                    end
                end
                default: begin
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    state_q      <= StIdle;
                end
            endcase
        end
    end

    // Word storage: cleared on reset, written only by a committed store.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else if (access_fire && wr_en) begin
            mem_q[acc_idx] <= wr_word;
`ifdef DM_WRITE_LOG_EN
            $display("@%08h: *%08h <= %08h", {acc_addr[31:2], 2'b00}, {acc_addr[31:2], 2'b00},
                     wr_word);
`endif
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: directed cases, backpressure, random traffic against a
// byte-level memory model, a zero-latency instance and reset during a wait.
module tb_dm_responder;

    localparam int Lat = 2;

    logic        clk;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        sw, sh, sb;
    logic [2:0]  dmext_op;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;

    logic        z_valid, z_ready, z_we;
    logic [31:0] z_addr, z_wdata;
    logic        z_sw, z_sh, z_sb;
    logic [2:0]  z_op;
    logic        z_resp_valid, z_resp_ready, z_resp_err;
    logic [31:0] z_resp_rdata;

    int checks = 0;
    int failures = 0;

    logic [7:0] mbytes [4096];

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  strb;
        logic [2:0]  op;
        logic [31:0] rd;
        logic        err;
    } row_t;

    dm_responder #(.ADDR_W(10), .LATENCY(Lat)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .sw(sw), .sh(sh), .sb(sb), .dmext_op(dmext_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dm_responder #(.ADDR_W(10), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(z_valid), .req_ready(z_ready), .req_we(z_we),
        .req_addr(z_addr), .req_wdata(z_wdata),
        .sw(z_sw), .sh(z_sh), .sb(z_sb), .dmext_op(z_op),
        .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
        .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_clear();
        for (int i = 0; i < 4096; i++) mbytes[i] = 8'h0;
    endfunction

    // Byte-addressed little-endian memory; the responder sees 4 KiB with wrap-around.
    function automatic void model_access(input logic we, input logic [31:0] addr,
                                         input logic [31:0] wdata, input logic [2:0] strb,
                                         input logic [2:0] op, output logic [31:0] rd,
                                         output logic err);
        int unsigned a;
        int v;
        a = addr % 4096;
        rd = 32'h0;
        err = 1'b0;
        if (we) begin
            if (strb[2]) begin
                if (a % 4 != 0) err = 1'b1;
                else for (int k = 0; k < 4; k++) mbytes[a + k] = 8'(wdata >> (8 * k));
            end else if (strb[1]) begin
                if (a % 2 != 0) err = 1'b1;
                else for (int k = 0; k < 2; k++) mbytes[a + k] = 8'(wdata >> (8 * k));
            end else if (strb[0]) begin
                mbytes[a] = wdata[7:0];
            end else begin
                err = 1'b1;
            end
        end else if (op == 3'd1 || op == 3'd2) begin
            v = int'(mbytes[a]);
            if (op == 3'd2 && v >= 128) v = v - 256;
            rd = 32'(v);
        end else if (op == 3'd3 || op == 3'd4) begin
            if (a % 2 != 0) err = 1'b1;
            else begin
                v = int'(mbytes[a]) + 256 * int'(mbytes[a + 1]);
                if (op == 3'd4 && v >= 32768) v = v - 65536;
                rd = 32'(v);
            end
        end else begin
            if (a % 4 != 0) err = 1'b1;
            else rd = {mbytes[a + 3], mbytes[a + 2], mbytes[a + 1], mbytes[a]};
        end
    endfunction

    // Drives one transaction on the LATENCY=2 instance and reports what was observed.
    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] strb, input logic [2:0] op, input int hold,
                        output bit accepted, output int lat, output logic [31:0] rd,
                        output logic er, output bit stable, output bit idle_ok);
        int n;
        accepted = 1'b0;
        lat = -1;
        rd = 32'h0;
        er = 1'b0;
        stable = 1'b0;
        idle_ok = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we = we;
        req_addr = addr;
        req_wdata = wdata;
        {sw, sh, sb} = strb;
        dmext_op = op;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            req_valid = 1'b0;
            return;
        end
        accepted = 1'b1;
        @(negedge clk);
        // Scramble request fields: the responder must use its captured copies.
        req_valid = 1'b0;
        req_we = 1'($urandom);
        req_addr = $urandom;
        req_wdata = $urandom;
        {sw, sh, sb} = 3'($urandom);
        dmext_op = 3'($urandom);
        n = 1;
        while (resp_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        lat = n;
        rd = resp_rdata;
        er = resp_err;
        stable = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_rdata !== rd || resp_err !== er ||
                req_ready !== 1'b0) stable = 1'b0;
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        idle_ok = (resp_valid === 1'b0) && (req_ready === 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        model_clear();
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 ||
            resp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got ready=%b valid=%b rdata=%h err=%b, want 1 0 0 0",
                     req_ready, resp_valid, resp_rdata, resp_err);
        end
        checks++;
        if (z_ready !== 1'b1 || z_resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_lat0: got ready=%b valid=%b, want 1 0", z_ready, z_resp_valid);
        end
        reset = 1'b1;
    endtask

    task automatic test_directed();
        row_t tbl[20];
        logic [31:0] mrd, rd;
        logic merr, er;
        bit acc, stab, idl;
        int lat;
        tbl[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 3'b100, 3'd0, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 32'h10,   32'h0,        3'b000, 3'd0, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h11,   32'h7F,       3'b001, 3'd0, 32'h0,        1'b0};
        tbl[3]  = '{1'b1, 32'h12,   32'h8001,     3'b010, 3'd0, 32'h0,        1'b0};
        tbl[4]  = '{1'b0, 32'h10,   32'h0,        3'b000, 3'd0, 32'h80017FEF, 1'b0};
        tbl[5]  = '{1'b0, 32'h13,   32'h0,        3'b000, 3'd2, 32'hFFFFFF80, 1'b0};
        tbl[6]  = '{1'b0, 32'h13,   32'h0,        3'b000, 3'd1, 32'h00000080, 1'b0};
        tbl[7]  = '{1'b0, 32'h12,   32'h0,        3'b000, 3'd4, 32'hFFFF8001, 1'b0};
        tbl[8]  = '{1'b1, 32'h06,   32'h12345678, 3'b100, 3'd0, 32'h0,        1'b1};
        tbl[9]  = '{1'b0, 32'h03,   32'h0,        3'b000, 3'd4, 32'h0,        1'b1};
        tbl[10] = '{1'b0, 32'h04,   32'h0,        3'b000, 3'd0, 32'h0,        1'b0};
        tbl[11] = '{1'b1, 32'h08,   32'hFFFFFFFF, 3'b000, 3'd0, 32'h0,        1'b1};
        tbl[12] = '{1'b0, 32'h08,   32'h0,        3'b000, 3'd0, 32'h0,        1'b0};
        tbl[13] = '{1'b0, 32'h12,   32'h0,        3'b000, 3'd3, 32'h00008001, 1'b0};
        tbl[14] = '{1'b0, 32'h10,   32'h0,        3'b000, 3'd7, 32'h80017FEF, 1'b0};
        tbl[15] = '{1'b1, 32'h20,   32'hA5A5A5A5, 3'b111, 3'd0, 32'h0,        1'b0};
        tbl[16] = '{1'b0, 32'h20,   32'h0,        3'b000, 3'd0, 32'hA5A5A5A5, 1'b0};
        tbl[17] = '{1'b1, 32'h26,   32'h00001234, 3'b011, 3'd0, 32'h0,        1'b0};
        tbl[18] = '{1'b0, 32'h24,   32'h0,        3'b000, 3'd0, 32'h12340000, 1'b0};
        tbl[19] = '{1'b0, 32'h1010, 32'h0,        3'b000, 3'd0, 32'h80017FEF, 1'b0};
        for (int i = 0; i < 20; i++) begin
            model_access(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].strb, tbl[i].op, mrd, merr);
            xact(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].strb, tbl[i].op, 0,
                 acc, lat, rd, er, stab, idl);
            checks++;
            if (!acc || lat != Lat + 1) begin
                failures++;
                $display("FAIL dir%0d_latency: got accepted=%0d lat=%0d, want 1 %0d",
                         i, acc, lat, Lat + 1);
            end
            checks++;
            if (rd !== tbl[i].rd || er !== tbl[i].err) begin
                failures++;
                $display("FAIL dir%0d_resp: got rdata=%h err=%b, want rdata=%h err=%b",
                         i, rd, er, tbl[i].rd, tbl[i].err);
            end
            checks++;
            if (!idl) begin
                failures++;
                $display("FAIL dir%0d_idle: got idle_ok=0, want 1", i);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] mrd, rd;
        logic merr, er;
        bit acc, stab, idl;
        int n, lat;
        model_access(1'b0, 32'h10, 32'h0, 3'b000, 3'd0, mrd, merr);
        @(negedge clk);
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = 32'h10;
        {sw, sh, sb} = 3'b000;
        dmext_op = 3'd0;
        @(negedge clk);
        // Second request held while busy: must not be taken until the responder is idle again.
        req_we = 1'b1;
        req_addr = 32'h30;
        req_wdata = 32'h5A5A1234;
        {sw, sh, sb} = 3'b100;
        n = 1;
        while (resp_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != Lat + 1 || resp_rdata !== mrd || resp_err !== 1'b0) begin
            failures++;
            $display("FAIL bp_first: got lat=%0d rdata=%h err=%b, want %0d %h 0",
                     n, resp_rdata, resp_err, Lat + 1, mrd);
        end
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== mrd || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold: got valid=%b rdata=%h ready=%b, want 1 %h 0",
                         resp_valid, resp_rdata, req_ready, mrd);
            end
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_idle: got valid=%b ready=%b, want 0 1", resp_valid, req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        model_access(1'b1, 32'h30, 32'h5A5A1234, 3'b100, 3'd0, mrd, merr);
        n = 1;
        while (resp_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != Lat + 1 || resp_err !== 1'b0) begin
            failures++;
            $display("FAIL bp_second: got lat=%0d err=%b, want %0d 0", n, resp_err, Lat + 1);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        xact(1'b0, 32'h30, 32'h0, 3'b000, 3'd0, 0, acc, lat, rd, er, stab, idl);
        checks++;
        if (rd !== 32'h5A5A1234 || er !== 1'b0) begin
            failures++;
            $display("FAIL bp_readback: got rdata=%h err=%b, want 5a5a1234 0", rd, er);
        end
    endtask

    task automatic test_random();
        logic [31:0] addr, wdata, mrd, rd;
        logic [2:0] strb, op;
        logic we, merr, er;
        bit acc, stab, idl;
        int lat, hold;
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom);
            addr = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 127));
            wdata = $urandom;
            strb = 3'($urandom);
            op = 3'($urandom);
            hold = $urandom_range(0, 2);
            model_access(we, addr, wdata, strb, op, mrd, merr);
            xact(we, addr, wdata, strb, op, hold, acc, lat, rd, er, stab, idl);
            checks++;
            if (!acc || lat != Lat + 1 || rd !== mrd || er !== merr || !stab || !idl) begin
                failures++;
                $display("FAIL rand%0d: we=%b addr=%h got lat=%0d rdata=%h err=%b stable=%0d idle=%0d, want lat=%0d rdata=%h err=%b",
                         i, we, addr, lat, rd, er, stab, idl, Lat + 1, mrd, merr);
            end
        end
    endtask

    task automatic test_lat0();
        logic        we_t[3]   = '{1'b1, 1'b0, 1'b0};
        logic [31:0] addr_t[3] = '{32'h1000, 32'h0, 32'h1002};
        logic [2:0]  op_t[3]   = '{3'd0, 3'd0, 3'd3};
        logic [31:0] exp_t[3]  = '{32'h0, 32'hCAFEF00D, 32'h0000CAFE};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (z_ready !== 1'b1) begin
                failures++;
                $display("FAIL lat0_%0d_ready: got %b, want 1", i, z_ready);
            end
            z_valid = 1'b1;
            z_we = we_t[i];
            z_addr = addr_t[i];
            z_wdata = 32'hCAFEF00D;
            {z_sw, z_sh, z_sb} = we_t[i] ? 3'b100 : 3'b000;
            z_op = op_t[i];
            @(negedge clk);
            z_valid = 1'b0;
            checks++;
            if (z_resp_valid !== 1'b1 || z_resp_rdata !== exp_t[i] || z_resp_err !== 1'b0) begin
                failures++;
                $display("FAIL lat0_%0d_resp: got valid=%b rdata=%h err=%b, want 1 %h 0",
                         i, z_resp_valid, z_resp_rdata, z_resp_err, exp_t[i]);
            end
            z_resp_ready = 1'b1;
            @(negedge clk);
            z_resp_ready = 1'b0;
        end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] rd;
        logic er;
        bit acc, stab, idl;
        int lat;
        @(negedge clk);
        req_valid = 1'b1;
        req_we = 1'b1;
        req_addr = 32'h20;
        req_wdata = 32'h11111111;
        {sw, sh, sb} = 3'b100;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstwait_idle: got ready=%b valid=%b, want 1 0", req_ready, resp_valid);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstwait_noresp: got valid=%b, want 0", resp_valid);
        end
        xact(1'b0, 32'h20, 32'h0, 3'b000, 3'd0, 0, acc, lat, rd, er, stab, idl);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0 || lat != Lat + 1) begin
            failures++;
            $display("FAIL rstwait_read20: got rdata=%h err=%b lat=%0d, want 0 0 %0d",
                     rd, er, lat, Lat + 1);
        end
        xact(1'b0, 32'h10, 32'h0, 3'b000, 3'd0, 0, acc, lat, rd, er, stab, idl);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            failures++;
            $display("FAIL rstwait_read10: got rdata=%h err=%b, want 0 0", rd, er);
        end
    endtask

    initial begin
        reset = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        sw = 1'b0; sh = 1'b0; sb = 1'b0; dmext_op = 3'd0; resp_ready = 1'b0;
        z_valid = 1'b0; z_we = 1'b0; z_addr = 32'h0; z_wdata = 32'h0;
        z_sw = 1'b0; z_sh = 1'b0; z_sb = 1'b0; z_op = 3'd0; z_resp_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_lat0();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1);
    end

endmodule
